idu: RTL and testbench

IDU -- requirements
Module: idu

---
 rtl/idu_if.sv | 33 +++
 rtl/idu.sv | 126 ++++++++++++
 tb/tb_idu.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/idu_if.sv
// Handshake and decoded-field bundle between fetch, the instruction decode buffer and execute.
// The master side drives fetch/execute inputs; the slave side is the decode unit itself.
interface idu_if;
    logic        idu_receive_valid;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic        idu_ready;
    logic        exu_ready;
    logic        flush;
    logic        idu_send_valid;
    logic [31:0] pc_out;
    logic [31:0] inst_out;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [31:0] imm;
    logic [3:0]  inst_type;
    logic        overrun;

    modport master (
        output idu_receive_valid, instruction, pc, exu_ready, flush,
        input  idu_ready, idu_send_valid, pc_out, inst_out, rd, rs1, rs2,
               funct3, funct7b5, imm, inst_type, overrun
    );

    modport slave (
        input  idu_receive_valid, instruction, pc, exu_ready, flush,
        output idu_ready, idu_send_valid, pc_out, inst_out, rd, rs1, rs2,
               funct3, funct7b5, imm, inst_type, overrun
    );
endinterface

// File: rtl/idu.sv
// RV32I instruction decode buffer: 2-entry FIFO that decodes at push time so the
// head entry's fields come straight from flops.
module idu (
    input  logic   clk,
    input  logic   rst,
    idu_if.slave   bus
);
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic        funct7b5;
        logic [31:0] imm;
        logic [3:0]  itype;
    } entry_t;

    function automatic entry_t decode(input logic [31:0] w, input logic [31:0] a);
        entry_t      e;
        logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
        imm_i = {{20{w[31]}}, w[31:20]};
        imm_s = {{20{w[31]}}, w[31:25], w[11:7]};
        imm_b = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
        imm_u = {w[31:12], 12'b0};
        imm_j = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
        e          = '0;
        e.pc       = a;
        e.inst     = w;
        e.rd       = w[11:7];
        e.rs1      = w[19:15];
        e.rs2      = w[24:20];
        e.funct3   = w[14:12];
        e.funct7b5 = w[30];
        e.itype    = 4'd15;
        e.imm      = '0;
        case (w[6:0])
            7'b0110111: begin e.itype = 4'd0; e.imm = imm_u; end
            7'b0010111: begin e.itype = 4'd1; e.imm = imm_u; end
            7'b1101111: begin e.itype = 4'd2; e.imm = imm_j; end
            7'b1100111: if (w[14:12] == 3'b000) begin e.itype = 4'd3; e.imm = imm_i; end
            7'b1100011: if (w[14:13] != 2'b01) begin e.itype = 4'd4; e.imm = imm_b; end
            7'b0000011: if (w[14:12] != 3'b011 && w[14:12] != 3'b110 && w[14:12] != 3'b111) begin
                e.itype = 4'd5; e.imm = imm_i;
            end
            7'b0100011: if (w[14] == 1'b0 && w[13:12] != 2'b11) begin e.itype = 4'd6; e.imm = imm_s; end
            7'b0010011: begin e.itype = 4'd7; e.imm = imm_i; end
            7'b0110011: e.itype = 4'd8;
            7'b1110011: begin e.itype = 4'd9; e.imm = imm_i; end
            default: ;
        endcase
        return e;
    endfunction

    entry_t     ent0_q, ent0_d, ent1_q, ent1_d;
    logic [1:0] count_q, count_d;
    logic       overrun_q, overrun_d;
    logic       ready, valid, push, pop;
    entry_t     incoming;

    assign ready    = (count_q != 2'd2);
    assign valid    = (count_q != 2'd0);
    assign push     = bus.idu_receive_valid && ready;
    assign pop      = valid && bus.exu_ready;
    assign incoming = decode(bus.instruction, bus.pc);

    always_comb begin
        ent0_d    = ent0_q;
        ent1_d    = ent1_q;
        count_d   = count_q;
        overrun_d = overrun_q || (bus.idu_receive_valid && !ready);
        // Head (ent0) only changes when it is empty or being popped, so a stalled head holds.
        if (bus.flush) begin
            count_d = 2'd0;
        end else begin
            case (count_q)
                2'd0: if (push) begin
                    ent0_d  = incoming;
                    count_d = 2'd1;
                end
                2'd1: begin
                    if (push && pop) begin
                        ent0_d = incoming;
                    end else if (push) begin
                        ent1_d  = incoming;
                        count_d = 2'd2;
                    end else if (pop) begin
                        count_d = 2'd0;
                    end
                end
                default: if (pop) begin
                    ent0_d  = ent1_q;
                    count_d = 2'd1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ent0_q    <= '0;
            ent1_q    <= '0;
            count_q   <= 2'd0;
            overrun_q <= 1'b0;
        end else begin
            ent0_q    <= ent0_d;
            ent1_q    <= ent1_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.idu_ready      = ready;
    assign bus.idu_send_valid = valid;
    assign bus.pc_out         = ent0_q.pc;
    assign bus.inst_out       = ent0_q.inst;
    assign bus.rd             = ent0_q.rd;
    assign bus.rs1            = ent0_q.rs1;
    assign bus.rs2            = ent0_q.rs2;
    assign bus.funct3         = ent0_q.funct3;
    assign bus.funct7b5       = ent0_q.funct7b5;
    assign bus.imm            = ent0_q.imm;
    assign bus.inst_type      = ent0_q.itype;
    assign bus.overrun        = overrun_q;
endmodule

// File: tb/tb_idu.sv
// Directed bench for idu: table of single decodes plus hand-written FIFO/flush/reset sequences.
module tb_idu;
    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    idu_if bus ();

    idu u_idu (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [3:0]  itype;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic        f7b5;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rv, input logic [31:0] w, input logic [31:0] a);
        bus.idu_receive_valid = rv;
        bus.instruction       = w;
        bus.pc                = a;
    endtask

    initial begin
        vecs[0]  = '{32'h00500093, 32'h80000000, 4'd7,  32'h00000005, 5'd1,  5'd0,  5'd5,  3'd0, 1'b0};
        vecs[1]  = '{32'hFE000EE3, 32'h80000004, 4'd4,  32'hFFFFFFFC, 5'd29, 5'd0,  5'd0,  3'd0, 1'b1};
        vecs[2]  = '{32'h00000000, 32'h80000008, 4'd15, 32'h00000000, 5'd0,  5'd0,  5'd0,  3'd0, 1'b0};
        vecs[3]  = '{32'h123452B7, 32'h8000000C, 4'd0,  32'h12345000, 5'd5,  5'd8,  5'd3,  3'd5, 1'b0};
        vecs[4]  = '{32'hFFFFF517, 32'h80000010, 4'd1,  32'hFFFFF000, 5'd10, 5'd31, 5'd31, 3'd7, 1'b1};
        vecs[5]  = '{32'h008000EF, 32'h80000014, 4'd2,  32'h00000008, 5'd1,  5'd0,  5'd8,  3'd0, 1'b0};
        vecs[6]  = '{32'h00009067, 32'h80000018, 4'd15, 32'h00000000, 5'd0,  5'd1,  5'd0,  3'd1, 1'b0};
        vecs[7]  = '{32'hFFC1A103, 32'h8000001C, 4'd5,  32'hFFFFFFFC, 5'd2,  5'd3,  5'd28, 3'd2, 1'b1};
        vecs[8]  = '{32'h00532423, 32'h80000020, 4'd6,  32'h00000008, 5'd8,  5'd6,  5'd5,  3'd2, 1'b0};
        vecs[9]  = '{32'h00533423, 32'h80000024, 4'd15, 32'h00000000, 5'd8,  5'd6,  5'd5,  3'd3, 1'b0};
        vecs[10] = '{32'h402081B3, 32'h80000028, 4'd8,  32'h00000000, 5'd3,  5'd1,  5'd2,  3'd0, 1'b1};
        vecs[11] = '{32'h00002063, 32'h8000002C, 4'd15, 32'h00000000, 5'd0,  5'd0,  5'd0,  3'd2, 1'b0};
        vecs[12] = '{32'h00000073, 32'h80000030, 4'd9,  32'h00000000, 5'd0,  5'd0,  5'd0,  3'd0, 1'b0};
        vecs[13] = '{32'h00003003, 32'h80000034, 4'd15, 32'h00000000, 5'd0,  5'd0,  5'd0,  3'd3, 1'b0};

        rst = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        bus.exu_ready = 1'b1;
        bus.flush     = 1'b0;
        #12;
        chk("rst_valid",   {31'b0, bus.idu_send_valid}, 32'd0);
        chk("rst_ready",   {31'b0, bus.idu_ready},      32'd1);
        chk("rst_overrun", {31'b0, bus.overrun},        32'd0);
        chk("rst_type",    {28'b0, bus.inst_type},      32'd0);
        chk("rst_pc_out",  bus.pc_out,                  32'd0);
        @(negedge clk);
        rst = 1'b1;
        step();

        // Single decodes: push, see it next cycle, popped the cycle after.
        for (int i = 0; i < 14; i++) begin
            drive(1'b1, vecs[i].inst, vecs[i].pc);
            step();
            drive(1'b0, 32'h0, 32'h0);
            chk($sformatf("v%0d_valid", i), {31'b0, bus.idu_send_valid}, 32'd1);
            chk($sformatf("v%0d_type", i),  {28'b0, bus.inst_type},      {28'b0, vecs[i].itype});
            chk($sformatf("v%0d_imm", i),   bus.imm,                     vecs[i].imm);
            chk($sformatf("v%0d_rd", i),    {27'b0, bus.rd},             {27'b0, vecs[i].rd});
            chk($sformatf("v%0d_rs1", i),   {27'b0, bus.rs1},            {27'b0, vecs[i].rs1});
            chk($sformatf("v%0d_rs2", i),   {27'b0, bus.rs2},            {27'b0, vecs[i].rs2});
            chk($sformatf("v%0d_f3", i),    {29'b0, bus.funct3},         {29'b0, vecs[i].f3});
            chk($sformatf("v%0d_f7b5", i),  {31'b0, bus.funct7b5},       {31'b0, vecs[i].f7b5});
            chk($sformatf("v%0d_pc", i),    bus.pc_out,                  vecs[i].pc);
            chk($sformatf("v%0d_inst", i),  bus.inst_out,                vecs[i].inst);
            step();
            chk($sformatf("v%0d_popped", i), {31'b0, bus.idu_send_valid}, 32'd0);
        end

        // Fill while stalled, overrun on third push, then drain in order.
        bus.exu_ready = 1'b0;
        drive(1'b1, 32'hAAAA0013, 32'h100);
        step();
        drive(1'b1, 32'hBBBB0013, 32'h104);
        step();
        chk("full_ready", {31'b0, bus.idu_ready}, 32'd0);
        chk("full_head",  bus.inst_out,           32'hAAAA0013);
        chk("full_ovr0",  {31'b0, bus.overrun},   32'd0);
        drive(1'b1, 32'hCCCC0013, 32'h108);
        step();
        drive(1'b0, 32'h0, 32'h0);
        chk("ovr_set",    {31'b0, bus.overrun},   32'd1);
        chk("ovr_head",   bus.inst_out,           32'hAAAA0013);
        chk("ovr_pc",     bus.pc_out,             32'h100);
        step();
        chk("stall_hold", bus.inst_out,           32'hAAAA0013);
        bus.exu_ready = 1'b1;
        step();
        chk("drain_b",       bus.inst_out,              32'hBBBB0013);
        chk("drain_b_valid", {31'b0, bus.idu_send_valid}, 32'd1);
        chk("drain_ready",   {31'b0, bus.idu_ready},      32'd1);
        step();
        chk("drain_empty",   {31'b0, bus.idu_send_valid}, 32'd0);
        chk("ovr_sticky",    {31'b0, bus.overrun},        32'd1);

        // Push and pop together at count=1: new entry replaces head.
        drive(1'b1, 32'h11110013, 32'h200);
        step();
        drive(1'b1, 32'h22220013, 32'h204);
        step();
        drive(1'b0, 32'h0, 32'h0);
        chk("pp_head",  bus.inst_out,               32'h22220013);
        chk("pp_valid", {31'b0, bus.idu_send_valid}, 32'd1);
        chk("pp_ready", {31'b0, bus.idu_ready},      32'd1);
        step();
        chk("pp_empty", {31'b0, bus.idu_send_valid}, 32'd0);

        // Flush at count=2 with a simultaneous push.
        bus.exu_ready = 1'b0;
        drive(1'b1, 32'h33330013, 32'h300);
        step();
        drive(1'b1, 32'h44440013, 32'h304);
        step();
        drive(1'b1, 32'h55550013, 32'h308);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        chk("fl_valid", {31'b0, bus.idu_send_valid}, 32'd0);
        chk("fl_ready", {31'b0, bus.idu_ready},      32'd1);
        step();
        chk("fl_still_empty", {31'b0, bus.idu_send_valid}, 32'd0);

        // Async reset between edges at count=1.
        drive(1'b1, 32'h66660013, 32'h400);
        step();
        drive(1'b0, 32'h0, 32'h0);
        chk("ar_pre_valid", {31'b0, bus.idu_send_valid}, 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("ar_valid",   {31'b0, bus.idu_send_valid}, 32'd0);
        chk("ar_ready",   {31'b0, bus.idu_ready},      32'd1);
        chk("ar_overrun", {31'b0, bus.overrun},        32'd0);
        chk("ar_inst",    bus.inst_out,                32'd0);
        #2 rst = 1'b1;
        bus.exu_ready = 1'b1;
        step();
        drive(1'b1, 32'h00500093, 32'h80000000);
        step();
        drive(1'b0, 32'h0, 32'h0);
        chk("ar_post_valid", {31'b0, bus.idu_send_valid}, 32'd1);
        chk("ar_post_type",  {28'b0, bus.inst_type},      32'd7);
        chk("ar_post_imm",   bus.imm,                     32'h5);
        step();
        chk("ar_post_pop",   {31'b0, bus.idu_send_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
